int_responder: RTL and testbench

Consumer end of the interrupt-manager handshake. Watches the manager's active-low summary line and issues a read strobe long enough for the manager's edge detector. Captures the 8-bit latched-line register and accumulates it into a local pending set. Presents a prioritised vector to the host CPU and clears each bit on a per-vector acknowledge.

---
 rtl/int_pkg.sv | 18 +
 rtl/int_prio_enc.sv | 25 ++
 rtl/int_responder.sv | 143 ++++++++++++++
 tb/tb_int_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt responder: FSM states, line/vector
// widths and default handshake timing.
package int_pkg;

    localparam int unsigned INT_LINES = 8;
    localparam int unsigned INT_VEC_W = 3;

    // Default strobe length and post-strobe settle time, in clocks.
    localparam int unsigned INT_RD_CYCLES_DEF     = 2;
    localparam int unsigned INT_SETTLE_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_SETTLE = 2'd2
    } int_state_e;

endpackage : int_pkg

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   i_req   - request vector, bit 0 has highest priority
//   o_valid - any request set
//   o_idx   - index of the lowest set request, 0 when none
module int_prio_enc
    import int_pkg::*;
(
    input  logic [INT_LINES-1:0] i_req,
    output logic                 o_valid,
    output logic [INT_VEC_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = int'(INT_LINES) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = INT_VEC_W'(i);
            end
        end
    end

endmodule : int_prio_enc

// File: rtl/int_responder.sv
// Consumer side of the interrupt-manager handshake. Strobes rd_o when the
// manager's summary line is low, captures the latched-line register into a
// local pending set, and presents a prioritised vector with per-vector ack.
// Optional feature macro: INT_RESPONDER_MASK_EN adds a writable enable mask.
// Ports:
//   fast_clock_i, n_reset_i - clock and async active-low reset
//   n_int_i, dat_i          - manager summary line (active low) and latches
//   rd_o                    - read strobe; manager clears on its falling edge
//   irq_o, vec_o, ack_i     - host interrupt, vector and acknowledge
//   pending_o               - raw pending set
//   mask_wr_i, mask_dat_i   - mask load (INT_RESPONDER_MASK_EN only)
module int_responder
    import int_pkg::*;
#(
    parameter int unsigned RD_CYCLES     = INT_RD_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = INT_SETTLE_CYCLES_DEF
) (
    input  logic                 fast_clock_i,
    input  logic                 n_reset_i,
    input  logic                 n_int_i,
    input  logic [INT_LINES-1:0] dat_i,
    output logic                 rd_o,
    output logic                 irq_o,
    output logic [INT_VEC_W-1:0] vec_o,
    input  logic                 ack_i,
    output logic [INT_LINES-1:0] pending_o
`ifdef INT_RESPONDER_MASK_EN
    ,
    input  logic                 mask_wr_i,
    input  logic [INT_LINES-1:0] mask_dat_i
`endif
);

    localparam int unsigned CNT_MAX = (RD_CYCLES > SETTLE_CYCLES) ? RD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    int_state_e           r_state;
    int_state_e           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_rd;
    logic                 w_rd_nxt;
    logic [INT_LINES-1:0] r_pend;
    logic [INT_LINES-1:0] w_pend_nxt;
    logic                 w_capture;
    logic [INT_LINES-1:0] w_mask;
    logic                 w_irq;
    logic [INT_VEC_W-1:0] w_vec;

    // Enable mask: writable register when the feature is built, else all-on.
`ifdef INT_RESPONDER_MASK_EN
    logic [INT_LINES-1:0] r_mask;

    always_ff @(posedge fast_clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            r_mask <= {INT_LINES{1'b1}};
        end else if (mask_wr_i) begin
            r_mask <= mask_dat_i;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = {INT_LINES{1'b1}};
`endif

    int_prio_enc u_prio (
        .i_req   (r_pend & w_mask),
        .o_valid (w_irq),
        .o_idx   (w_vec)
    );

    // State, counter, strobe and pending registers.
    always_ff @(posedge fast_clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= w_rd_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state: strobe for RD_CYCLES, capture on the last strobe edge,
    // then blank n_int_i for SETTLE_CYCLES while the manager clears.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_nxt    = r_rd;
        w_capture   = 1'b0;
        w_pend_nxt  = r_pend;

        case (r_state)
            ST_IDLE: begin
                if (!n_int_i) begin
                    w_state_nxt = ST_READ;
                    w_rd_nxt    = 1'b1;
                    w_cnt_nxt   = CNT_W'(RD_CYCLES - 1);
                end
            end
            ST_READ: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_rd_nxt    = 1'b0;
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rd_nxt    = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase

        // Ack clears first so a same-cycle capture of that bit wins.
        if (ack_i && w_irq) begin
            w_pend_nxt[w_vec] = 1'b0;
        end
        if (w_capture) begin
            w_pend_nxt = w_pend_nxt | dat_i;
        end
    end

    assign rd_o      = r_rd;
    assign pending_o = r_pend;
    assign irq_o     = w_irq;
    assign vec_o     = w_vec;

endmodule : int_responder

// File: tb/tb_int_responder.sv
// Bench for int_responder: directed vector table, hand sequences for
// back-to-back reads, masking and mid-read reset, plus randomized traffic
// checked against a transaction-timing model.
module tb_int_responder;
    import int_pkg::*;

    localparam int R = 2;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       n_int = 1'b1;
    logic [7:0] dat = 8'h00;
    logic       ack = 1'b0;
    logic       rd;
    logic       irq;
    logic [2:0] vec;
    logic [7:0] pend;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_dat = 8'hFF;

    always #5 clk = ~clk;

    int_responder dut (
        .fast_clock_i (clk),
        .n_reset_i    (rst_n),
        .n_int_i      (n_int),
        .dat_i        (dat),
        .rd_o         (rd),
        .irq_o        (irq),
        .vec_o        (vec),
        .ack_i        (ack),
        .pending_o    (pend)
`ifdef INT_RESPONDER_MASK_EN
        ,
        .mask_wr_i    (mask_wr),
        .mask_dat_i   (mask_dat)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: a read is a transaction starting at edge m_start,
    // strobe visible for R edges, capture at m_start+R, next start allowed
    // from m_start+R+S+1.
    int         m_edge    = 0;
    int         m_start   = 0;
    int         m_next_ok = 0;
    bit         m_reading = 1'b0;
    logic [7:0] m_pend    = 8'h00;
    logic [7:0] m_mask    = 8'hFF;

    function automatic logic [2:0] lowest(input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            if (x[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] en;
        bit cap;
        en  = m_pend & m_mask;
        cap = 1'b0;
        if (m_reading && m_edge == m_start + R) begin
            cap       = 1'b1;
            m_reading = 1'b0;
        end else if (!m_reading && m_edge >= m_next_ok && !n_int) begin
            m_reading = 1'b1;
            m_start   = m_edge;
            m_next_ok = m_edge + R + S + 1;
        end
        if (ack && en != 8'h00) m_pend[lowest(en)] = 1'b0;
        if (cap) m_pend = m_pend | dat;
`ifdef INT_RESPONDER_MASK_EN
        if (mask_wr) m_mask = mask_dat;
`endif
        m_edge++;
    endtask

    task automatic model_reset();
        m_reading = 1'b0;
        m_pend    = 8'h00;
        m_mask    = 8'hFF;
        m_next_ok = m_edge;
    endtask

    task automatic chk_model(input string nm);
        logic [7:0] en;
        en = m_pend & m_mask;
        chk(nm, 32'({rd, irq, vec, pend}), 32'({m_reading, |en, lowest(en), m_pend}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       n_int;
        logic [7:0] dat;
        logic       ack;
        logic       rd;
        logic [7:0] pend;
        logic       irq;
        logic [2:0] vec;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int last_rise;
        int rises;
        logic prev_rd;

        tbl[0]  = '{1'b0, 8'h24, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 8'h24, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 8'h24, 1'b0, 1'b0, 8'h24, 1'b1, 3'd2};
        tbl[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h20, 1'b1, 3'd5};
        tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[6]  = '{1'b0, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0};
        tbl[12] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[13] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[14] = '{1'b1, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 3'd0};
        tbl[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 3'd7};
        tbl[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};

        // Reset state.
        #12;
        chk("reset_outputs", 32'({rd, irq, vec, pend}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle line: no strobe, outputs stay at reset values.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", 32'({rd, irq, vec, pend}), 32'h0);
        end

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            n_int = tbl[i].n_int;
            dat   = tbl[i].dat;
            ack   = tbl[i].ack;
            step();
            chk($sformatf("tbl[%0d]", i), 32'({rd, irq, vec, pend}),
                32'({tbl[i].rd, tbl[i].irq, tbl[i].vec, tbl[i].pend}));
        end
        ack = 1'b0;

        // Summary line held low: back-to-back reads every R+S+1 clocks.
        n_int = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_int     = 1'b0;
        prev_rd   = rd;
        last_rise = -1;
        rises     = 0;
        for (int i = 0; i < 36; i++) begin
            dat = 8'(1 << (i % 8));
            step();
            chk_model("hold_low");
            if (rd && !prev_rd) begin
                if (last_rise >= 0) chk("repeat_period", 32'(i - last_rise), 32'(R + S + 1));
                last_rise = i;
                rises++;
            end
            prev_rd = rd;
        end
        chk("repeat_count", 32'(rises), 32'd6);
        n_int = 1'b1;

`ifdef INT_RESPONDER_MASK_EN
        // Masked capture, then unmask raises irq in the same cycle.
        ack = 1'b1;
        for (int i = 0; i < 12; i++) step();
        ack      = 1'b0;
        mask_wr  = 1'b1;
        mask_dat = 8'hFE;
        step();
        mask_wr  = 1'b0;
        n_int    = 1'b0;
        dat      = 8'h01;
        step();
        n_int = 1'b1;
        step();
        step();
        chk("mask_hold", 32'({irq, pend}), 32'({1'b0, 8'h01}));
        mask_wr  = 1'b1;
        mask_dat = 8'hFF;
        step();
        mask_wr = 1'b0;
        chk("mask_open", 32'({irq, vec}), 32'({1'b1, 3'd0}));
        for (int i = 0; i < 4; i++) step();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            n_int = ($urandom_range(0, 2) == 0);
            dat   = 8'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
`ifdef INT_RESPONDER_MASK_EN
            mask_wr  = ($urandom_range(0, 9) == 0);
            mask_dat = 8'($urandom);
`endif
            step();
            chk_model("random");
        end
        ack     = 1'b0;
        mask_wr = 1'b0;

        // Reset in the first strobe cycle.
        n_int = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_int = 1'b0;
        dat   = 8'h3C;
        step();
        n_int = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset_pend", 32'(pend & 8'h3C), 32'h3C);
        n_int = 1'b0;
        step();
        chk("rd_first_cycle", 32'(rd), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_read", 32'({rd, irq, vec, pend}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n_int = 1'b1;
        step();
        chk_model("post_reset_idle");
        n_int = 1'b0;
        step();
        chk("post_reset_read", 32'(rd), 32'd1);
        chk_model("post_reset_model");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_int_responder
